// File: rtl/xor_diff_decoder_4b_if.sv
// Valid/ready nibble stream bundle for the XOR differential decoder.
// Input stream (in_*) and output stream (out_*) share one interface.
interface xor_diff_decoder_4b_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    // Driver/consumer side: sources encoded beats and sinks decoded beats.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    // Decoder side.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/xor_diff_decoder_4b.sv
// Streaming XOR-chain differential decoder with a per-frame check nibble,
// a frame counter and a single registered output stage.
module xor_diff_decoder_4b #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    xor_diff_decoder_4b_if.slave bus,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic [7:0]           frame_cnt
);

    typedef enum logic {
        S_IDLE,
        S_BODY
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic             r_out_valid;
    logic             r_frame_done;
    logic             r_frame_err;
    logic [7:0]       r_frame_cnt;

    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_hist;
    logic [WIDTH-1:0] w_acc_cur;
    logic [WIDTH-1:0] w_decoded;
    logic             w_chk_err;

    // The output register may be refilled in the same cycle it drains.
    assign w_in_ready = rst_n & (~r_out_valid | bus.out_ready);
    assign w_accept   = bus.in_valid & w_in_ready;

    // First beat of a frame uses INIT as history and an empty check accumulator.
    assign w_hist     = (r_state == S_IDLE) ? INIT : r_prev;
    assign w_acc_cur  = (r_state == S_IDLE) ? '0   : r_acc;
    assign w_decoded  = bus.in_data ^ w_hist;
    assign w_chk_err  = (w_decoded != w_acc_cur);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_prev       <= INIT;
            r_acc        <= '0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values; the default below makes frame_done a pulse.
            r_frame_done <= 1'b0;
            if (w_accept) begin
                r_out_data  <= w_decoded;
                r_out_last  <= bus.in_last;
                r_out_valid <= 1'b1;
                r_prev      <= bus.in_data;
                if (bus.in_last) begin
                    r_state      <= S_IDLE;
                    r_acc        <= '0;
                    r_frame_done <= 1'b1;
                    r_frame_err  <= w_chk_err;
                    r_frame_cnt  <= r_frame_cnt + 8'd1;
                end else begin
                    r_state <= S_BODY;
                    r_acc   <= w_acc_cur ^ w_decoded;
                end
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign frame_done    = r_frame_done;
    assign frame_err     = r_frame_err;
    assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_xor_diff_decoder_4b.sv
// Directed bench for xor_diff_decoder_4b: decoded stream, frame check,
// backpressure, mid-frame reset and frame counter wrap.
module tb_xor_diff_decoder_4b;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_done;
    logic       frame_err;
    logic [7:0] frame_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [4:0] out_q[$];      // {last, data}
    int         out_cyc_q[$];
    logic [8:0] done_q[$];     // {err, cnt}

    xor_diff_decoder_4b_if #(.WIDTH(4)) bus ();

    xor_diff_decoder_4b #(.WIDTH(4), .INIT(4'b0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change at posedge+2, so negedge values hold until the next edge.
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            out_q.push_back({bus.out_last, bus.out_data});
            out_cyc_q.push_back(cyc);
        end
        if (frame_done) done_q.push_back({frame_err, frame_cnt});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] d, input logic l);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic pop_out(input string tag, input logic [3:0] d, input logic l);
        logic [4:0] v;
        if (out_q.size() == 0) begin
            check({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            v = out_q.pop_front();
            void'(out_cyc_q.pop_front());
            check({tag, "_data"}, {28'd0, v[3:0]}, {28'd0, d});
            check({tag, "_last"}, {31'd0, v[4]}, {31'd0, l});
        end
    endtask

    task automatic pop_done(input string tag, input logic err, input logic [7:0] cnt);
        logic [8:0] v;
        if (done_q.size() == 0) begin
            check({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            v = done_q.pop_front();
            check({tag, "_err"}, {31'd0, v[8]}, {31'd0, err});
            check({tag, "_cnt"}, {24'd0, v[7:0]}, {24'd0, cnt});
        end
    endtask

    task automatic apply_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        out_q.delete();
        out_cyc_q.delete();
        done_q.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        int errs;
        int c0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        check("rst_out_data",  {28'd0, bus.out_data},  32'd0);
        check("rst_frame_done", {31'd0, frame_done},   32'd0);
        check("rst_frame_cnt", {24'd0, frame_cnt},     32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("first_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #2;

        // Good frame 3,6,0 -> 3,5,6.
        send(4'd3, 1'b0); send(4'd6, 1'b0); send(4'd0, 1'b1);
        settle();
        pop_out("f1_b0", 4'd3, 1'b0);
        pop_out("f1_b1", 4'd5, 1'b0);
        pop_out("f1_b2", 4'd6, 1'b1);
        pop_done("f1_done", 1'b0, 8'd1);
        check("f1_extra_done", done_q.size(), 32'd0);

        // Corrupted check beat -> 3,5,7 with error.
        apply_reset();
        send(4'd3, 1'b0); send(4'd6, 1'b0); send(4'd1, 1'b1);
        settle();
        pop_out("f2_b0", 4'd3, 1'b0);
        pop_out("f2_b1", 4'd5, 1'b0);
        pop_out("f2_b2", 4'd7, 1'b1);
        pop_done("f2_done", 1'b1, 8'd1);

        // Back-to-back single-beat frames, no bubble.
        apply_reset();
        send(4'd0, 1'b1); send(4'd5, 1'b1);
        settle();
        if (out_cyc_q.size() >= 2) check("sb_no_bubble", out_cyc_q[1] - out_cyc_q[0], 32'd1);
        else check("sb_beats", out_cyc_q.size(), 32'd2);
        pop_out("sb_b0", 4'd0, 1'b1);
        pop_out("sb_b1", 4'd5, 1'b1);
        pop_done("sb_d0", 1'b0, 8'd1);
        pop_done("sb_d1", 1'b1, 8'd2);

        // Backpressure mid-frame.
        apply_reset();
        send(4'd3, 1'b0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'd6;
        bus.in_last   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
            check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_out_data",  {28'd0, bus.out_data},  32'd3);
        end
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        send(4'd6, 1'b0); send(4'd0, 1'b1);
        settle();
        pop_out("bp_b0", 4'd3, 1'b0);
        pop_out("bp_b1", 4'd5, 1'b0);
        pop_out("bp_b2", 4'd6, 1'b1);
        pop_done("bp_done", 1'b0, 8'd1);

        // Reset after two beats discards the partial frame.
        apply_reset();
        send(4'd3, 1'b0); send(4'd6, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mr_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mr_out_data",  {28'd0, bus.out_data},  32'd0);
        check("mr_in_ready",  {31'd0, bus.in_ready},  32'd0);
        check("mr_no_done",   done_q.size(),          32'd0);
        @(posedge clk);
        #2;
        out_q.delete();
        out_cyc_q.delete();
        rst_n = 1'b1;
        send(4'd3, 1'b0); send(4'd6, 1'b0); send(4'd0, 1'b1);
        settle();
        pop_out("mr_b0", 4'd3, 1'b0);
        pop_out("mr_b1", 4'd5, 1'b0);
        pop_out("mr_b2", 4'd6, 1'b1);
        pop_done("mr_done", 1'b0, 8'd1);

        // 256 single-beat frames of 0: counter wraps, never an error.
        apply_reset();
        for (int i = 0; i < 256; i++) send(4'd0, 1'b1);
        settle();
        check("wrap_done_count", done_q.size(), 32'd256);
        errs = 0;
        c0 = 0;
        for (int i = 0; i < done_q.size(); i++) begin
            if (done_q[i][8]) errs++;
            if (done_q[i][7:0] != 8'((i + 1) % 256)) c0++;
        end
        check("wrap_err_count", errs, 32'd0);
        check("wrap_cnt_seq", c0, 32'd0);
        check("wrap_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        check("wrap_done_low", {31'd0, frame_done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
